// File: rtl/calc_operand_regs_pkg.sv
// Shared definitions for the calculator operand register file.
//   calc_state_e : control state (entry vs. waiting on the arithmetic unit)
//   Op*          : operator codes carried in op_reg
//   calc_dw()    : operand width in bits for a given hex-digit count
package calc_operand_regs_pkg;

  typedef enum logic [0:0] {
    StEntry,
    StWaitAns
  } calc_state_e;

  localparam int unsigned OpAdd = 0;
  localparam int unsigned OpSub = 1;
  localparam int unsigned OpMul = 2;
  localparam int unsigned OpDiv = 3;

  function automatic int unsigned calc_dw(input int unsigned digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/calc_operand_regs_if.sv
// Bus between the keypad/arithmetic side and the operand register file.
//   master : keypad decoder + arithmetic unit (drive key pulses and ans)
//   slave  : calc_operand_regs (drives operands, request and status)
interface calc_operand_regs_if
  import calc_operand_regs_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned OPW    = 2
);
  localparam int unsigned DW = calc_dw(DIGITS);
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic           newhex;
  logic [3:0]     hexcode;
  logic           newop;
  logic [OPW-1:0] opcode;
  logic           eq;
  logic           bksp;
  logic           clr;
  logic [DW-1:0]  ans;
  logic           ans_valid;
  logic [DW-1:0]  v1_reg;
  logic [DW-1:0]  v2_reg;
  logic [OPW-1:0] op_reg;
  logic           calc_req;
  logic           busy;
  logic [CW-1:0]  digit_cnt;
  logic           full;
  logic           err;

  modport master (
    output newhex, hexcode, newop, opcode, eq, bksp, clr, ans, ans_valid,
    input  v1_reg, v2_reg, op_reg, calc_req, busy, digit_cnt, full, err
  );

  modport slave (
    input  newhex, hexcode, newop, opcode, eq, bksp, clr, ans, ans_valid,
    output v1_reg, v2_reg, op_reg, calc_req, busy, digit_cnt, full, err
  );

endinterface

// File: rtl/calc_digit_shifter.sv
// Combinational next-value logic for a digit-entry operand.
//   v1, cnt, fresh            : current operand, digit count, overwrite flag
//   hex_en, hexcode           : apply a digit key (wins over bksp_en)
//   bksp_en                   : apply a backspace
//   v1_next, cnt_next,
//   fresh_next                : resulting values (pass-through when idle)
//   clr_err                   : a fresh digit starts a new entry, clearing err
module calc_digit_shifter
  import calc_operand_regs_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic [calc_dw(DIGITS)-1:0]  v1,
  input  logic [$clog2(DIGITS+1)-1:0] cnt,
  input  logic                        fresh,
  input  logic                        hex_en,
  input  logic [3:0]                  hexcode,
  input  logic                        bksp_en,
  output logic [calc_dw(DIGITS)-1:0]  v1_next,
  output logic [$clog2(DIGITS+1)-1:0] cnt_next,
  output logic                        fresh_next,
  output logic                        clr_err
);
  localparam int unsigned DW = calc_dw(DIGITS);
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(DIGITS);

  // Concatenate then drop the top nibble; also covers DIGITS == 1.
  logic [DW+3:0] shifted_in;
  assign shifted_in = {v1, hexcode};

  always_comb begin
    v1_next    = v1;
    cnt_next   = cnt;
    fresh_next = fresh;
    clr_err    = 1'b0;
    if (hex_en) begin
      if (fresh) begin
        v1_next    = DW'(hexcode);
        cnt_next   = CW'(1);
        fresh_next = 1'b0;
        clr_err    = 1'b1;
      end else if (cnt < MaxCnt) begin
        v1_next  = shifted_in[DW-1:0];
        cnt_next = cnt + CW'(1);
      end
    end else if (bksp_en) begin
      if (fresh) begin
        v1_next  = '0;
        cnt_next = '0;
      end else begin
        v1_next = v1 >> 4;
        if (cnt != '0) cnt_next = cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/calc_operand_regs.sv
// Operand register file for the hex calculator datapath.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : key pulses (newhex/newop/eq/bksp/clr), ans/ans_valid in;
//                  v1_reg/v2_reg/op_reg, calc_req, busy, digit_cnt, full, err out
// Assembles digits into v1, latches v2/op on an operator key and holds a
// result request on eq until ans_valid, clr or a timeout.
module calc_operand_regs
  import calc_operand_regs_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned OPW         = 2,
  parameter int unsigned ANS_TIMEOUT = 15
) (
  input logic                clock,
  input logic                reset,
  calc_operand_regs_if.slave bus
);
  localparam int unsigned DW = calc_dw(DIGITS);
  localparam int unsigned CW = $clog2(DIGITS + 1);
  // Counter only needs to reach ANS_TIMEOUT-1; the next miss is the timeout.
  localparam int unsigned TW = (ANS_TIMEOUT < 2) ? 1 : $clog2(ANS_TIMEOUT);
  localparam logic [TW-1:0] TimeoutLast = TW'(ANS_TIMEOUT - 1);
  localparam logic [CW-1:0] MaxCnt = CW'(DIGITS);

  calc_state_e    state_q, state_d;
  logic [DW-1:0]  v1_q, v1_d;
  logic [DW-1:0]  v2_q, v2_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           fresh_q, fresh_d;
  logic           err_q, err_d;
  logic           req_q, req_d;
  logic           busy_q, busy_d;
  logic           full_q, full_d;

  logic           hex_en, bksp_en;
  logic [DW-1:0]  sh_v1;
  logic [CW-1:0]  sh_cnt;
  logic           sh_fresh, sh_clr_err;

  calc_digit_shifter #(
    .DIGITS (DIGITS)
  ) u_shifter (
    .v1         (v1_q),
    .cnt        (cnt_q),
    .fresh      (fresh_q),
    .hex_en     (hex_en),
    .hexcode    (bus.hexcode),
    .bksp_en    (bksp_en),
    .v1_next    (sh_v1),
    .cnt_next   (sh_cnt),
    .fresh_next (sh_fresh),
    .clr_err    (sh_clr_err)
  );

  always_comb begin
    state_d = state_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    fresh_d = fresh_q;
    err_d   = err_q;
    req_d   = req_q;
    busy_d  = busy_q;
    hex_en  = 1'b0;
    bksp_en = 1'b0;
    unique case (state_q)
      StEntry: begin
        if (bus.clr) begin
          v1_d    = '0;
          cnt_d   = '0;
          fresh_d = 1'b1;
          err_d   = 1'b0;
        end else if (bus.eq) begin
          state_d = StWaitAns;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          tmo_d   = '0;
        end else if (bus.newop) begin
          // v1 stays on the display until the next digit overwrites it.
          v2_d    = v1_q;
          op_d    = bus.opcode;
          fresh_d = 1'b1;
          cnt_d   = '0;
        end else begin
          hex_en  = bus.newhex;
          bksp_en = bus.bksp;
          v1_d    = sh_v1;
          cnt_d   = sh_cnt;
          fresh_d = sh_fresh;
          if (sh_clr_err) err_d = 1'b0;
        end
      end
      StWaitAns: begin
        if (bus.clr) begin
          // Abort; a same-cycle ans is discarded.
          state_d = StEntry;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          v1_d    = '0;
          cnt_d   = '0;
          fresh_d = 1'b1;
          err_d   = 1'b0;
        end else if (bus.ans_valid) begin
          state_d = StEntry;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          v1_d    = bus.ans;
          cnt_d   = '0;
          fresh_d = 1'b1;
        end else if (tmo_q == TimeoutLast) begin
          state_d = StEntry;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = StEntry;
    endcase
    full_d = (cnt_d == MaxCnt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StEntry;
      v1_q    <= '0;
      v2_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      fresh_q <= 1'b1;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      fresh_q <= fresh_d;
      err_q   <= err_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
    end
  end

  assign bus.v1_reg    = v1_q;
  assign bus.v2_reg    = v2_q;
  assign bus.op_reg    = op_q;
  assign bus.calc_req  = req_q;
  assign bus.busy      = busy_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.full      = full_q;
  assign bus.err       = err_q;

endmodule
